aes_key_expand: RTL

- AES-128 key schedule stage, directly upstream of add_round_key.
- Takes the 128-bit cipher key and streams round keys 0..10 one at a time on a valid/ready handshake. add_round_key (and the round controller) consumes each key together with its round number.
- Each round key is computed iteratively from the previous one, so no 1408-bit key store is needed.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_key_expand_if.sv | 23 ++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_key_expand.sv | 101 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: S-box, round constants, key-schedule sizes and
// the key-expansion state encoding.
package aes_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int RNUM_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_e;

    // RCON[i] is the round constant used to derive round key i+1.
    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant needed to step from round key r to round key r+1.
    function automatic logic [7:0] next_rcon(input logic [RNUM_W-1:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NR; i++) begin
            if (r == RNUM_W'(i)) v = RCON[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Round-key stream bundle between the key schedule and its consumer.
interface aes_key_expand_if
    import aes_pkg::*;
;
    logic              start;
    logic [KEY_W-1:0]  key_in;
    logic              key_ready;
    logic [KEY_W-1:0]  round_key;
    logic [RNUM_W-1:0] round_num;
    logic              key_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, key_in, key_ready,
        input  round_key, round_num, key_valid, busy, done
    );

    modport slave (
        input  start, key_in, key_ready,
        output round_key, round_num, key_valid, busy, done
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    assign out_byte = SBOX[in_byte];
endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 one per handshake,
// deriving each key from the previous one held in a single register.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    aes_key_expand_if.slave bus
);
    ks_state_e         state_q, state_d;
    logic [KEY_W-1:0]  rk_q, rk_d;
    logic [RNUM_W-1:0] rn_q, rn_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [31:0]       w0, w1, w2, w3;
    logic [31:0]       rot_w, sub_w, t_w;
    logic [31:0]       n0, n1, n2, n3;
    logic [KEY_W-1:0]  next_key;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*i +: 8]),
            .out_byte (sub_w[8*i +: 8])
        );
    end

    assign t_w      = sub_w ^ {next_rcon(rn_q), 24'h000000};
    assign n0       = w0 ^ t_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        rn_d    = rn_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The done cycle still reads as IDLE but must not accept a new key.
                if (bus.start && !done_q) begin
                    rk_d    = bus.key_in;
                    rn_d    = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (valid_q && bus.key_ready) begin
                    if (rn_q == RNUM_W'(NR)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rk_d = next_key;
                        rn_d = rn_q + RNUM_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            rn_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            rn_q    <= rn_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.round_key = rk_q;
    assign bus.round_num = rn_q;
    assign bus.key_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
